// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 VGA counters, region decode and registered pixel/sync output stage.
module vga_timing_gen #(
    parameter int H_ACT    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACT    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [11:0] d_in,
    output logic [9:0]  col_addr,
    output logic [8:0]  row_addr,
    output logic        rdn,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b,
    output logic        hs,
    output logic        vs,
    output logic        frame_start
);
    localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS  = 10'(H_ACT);
    localparam logic [9:0] V_VIS  = 10'(V_ACT);
    localparam logic [9:0] HS_BEG = 10'(H_ACT + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACT + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACT + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACT + V_FP + V_SYNC);
    localparam logic       POL    = (SYNC_POL != 0);

    if (H_TOT > 1024 || V_TOT > 1024) begin : g_bad_totals
        $error("vga_timing_gen: line/frame totals must fit 10-bit counters");
    end

    logic [9:0] h_cnt, v_cnt;
    logic       active, hsync_int, vsync_int;

    always_comb begin
        active    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        hsync_int = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
        vsync_int = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
        col_addr  = active ? h_cnt : '0;
        row_addr  = active ? v_cnt[8:0] : '0;
        rdn       = ~active;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= (h_cnt == H_LAST) ? '0 : h_cnt + 10'd1;
            if (h_cnt == H_LAST)
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end
    end

    // Colour is gated by active so blanking never leaks d_in onto the connector.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            {b, g, r}   <= '0;
            hs          <= ~POL;
            vs          <= ~POL;
            frame_start <= 1'b0;
        end else begin
            {b, g, r}   <= active ? d_in : 12'h000;
            hs          <= hsync_int ^ ~POL;
            vs          <= vsync_int ^ ~POL;
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed scoreboard bench; vertical timing shortened (27 lines/frame) to keep runs short.
module tb_vga_timing_gen;
    logic        clk = 0;
    logic        rstn;
    logic [11:0] d_in;
    logic [9:0]  col_addr, col1;
    logic [8:0]  row_addr, row1;
    logic        rdn, rdn1, hs, vs, fs, hs1, vs1, fs1;
    logic [3:0]  r, g, b, r1, g1, b1;

    always #5 clk = ~clk;

    vga_timing_gen #(.V_ACT(20), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(0)) dut (
        .clk(clk), .rstn(rstn), .d_in(d_in), .col_addr(col_addr), .row_addr(row_addr),
        .rdn(rdn), .r(r), .g(g), .b(b), .hs(hs), .vs(vs), .frame_start(fs));

    vga_timing_gen #(.V_ACT(20), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1)) dut_pol1 (
        .clk(clk), .rstn(rstn), .d_in(d_in), .col_addr(col1), .row_addr(row1),
        .rdn(rdn1), .r(r1), .g(g1), .b(b1), .hs(hs1), .vs(vs1), .frame_start(fs1));

    // Blanking always presents all-ones so any leak onto r/g/b is visible.
    always_comb d_in = rdn ? 12'hFFF : {col_addr[3:0], row_addr[3:0], 4'h5};

    typedef struct {
        int         k;
        logic [9:0] col;
        logic [8:0] row;
        logic       rdn;
        logic [11:0] bgr;
        logic       hs, vs, fs;
    } exp_t;

    exp_t sb[$];
    int   k = -1;
    int   checks = 0, errors = 0;
    int   row_max = 0;
    bit   epoch1 = 0;

    task automatic push(input int kk, input int col, input int row, input bit rd,
                        input logic [11:0] bgr, input bit h, input bit v, input bit f);
        exp_t e;
        e.k = kk; e.col = 10'(col); e.row = 9'(row); e.rdn = rd;
        e.bgr = bgr; e.hs = h; e.vs = v; e.fs = f;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input int kk, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s k=%0d got=%h want=%h", name, kk, act, exp);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].k == k) begin
            exp_t e;
            e = sb.pop_front();
            chk("pix", k, {col_addr, row_addr, rdn, b, g, r}, {e.col, e.row, e.rdn, e.bgr});
            chk("sync", k, {hs, vs}, {e.hs, e.vs});
            chk("sync_pol1", k, {hs1, vs1}, {~e.hs, ~e.vs});
            chk("frame_start", k, fs, e.fs);
        end
        if (epoch1 && int'(row_addr) > row_max) row_max = int'(row_addr);
    end

    initial begin
        rstn = 0;
        repeat (4) @(posedge clk);
        #1 push(-1, 0, 0, 0, 12'h000, 1, 1, 0);
        @(posedge clk);
        #1 rstn = 1; k = 0; epoch1 = 1;
        push(0,     0,   0,  0, 12'h000, 1, 1, 0);
        push(1,     1,   0,  0, 12'h005, 1, 1, 1);
        push(2,     2,   0,  0, 12'h105, 1, 1, 0);
        push(640,   0,   0,  1, 12'hF05, 1, 1, 0);
        push(641,   0,   0,  1, 12'h000, 1, 1, 0);
        push(656,   0,   0,  1, 12'h000, 1, 1, 0);
        push(657,   0,   0,  1, 12'h000, 0, 1, 0);
        push(701,   0,   0,  1, 12'h000, 0, 1, 0);
        push(752,   0,   0,  1, 12'h000, 0, 1, 0);
        push(753,   0,   0,  1, 12'h000, 1, 1, 0);
        push(800,   0,   1,  0, 12'h000, 1, 1, 0);
        push(801,   1,   1,  0, 12'h015, 1, 1, 0);
        push(1457,  0,   0,  1, 12'h000, 0, 1, 0);
        push(1552,  0,   0,  1, 12'h000, 0, 1, 0);
        push(1553,  0,   0,  1, 12'h000, 1, 1, 0);
        push(1638,  38,  2,  0, 12'h525, 1, 1, 0);
        push(15205, 5,   19, 0, 12'h435, 1, 1, 0);
        push(16000, 0,   0,  1, 12'h000, 1, 1, 0);
        push(17600, 0,   0,  1, 12'h000, 1, 1, 0);
        push(17601, 0,   0,  1, 12'h000, 1, 0, 0);
        push(19200, 0,   0,  1, 12'h000, 1, 0, 0);
        push(19201, 0,   0,  1, 12'h000, 1, 1, 0);
        push(21600, 0,   0,  0, 12'h000, 1, 1, 0);
        push(21601, 1,   0,  0, 12'h005, 1, 1, 1);
        push(21602, 2,   0,  0, 12'h105, 1, 1, 0);
        push(29723, 123, 10, 0, 12'hAA5, 1, 1, 0);
        while (k < 29723) begin
            @(posedge clk);
            #1 k++;
        end
        epoch1 = 0;
        rstn = 0;
        @(posedge clk);
        #1 rstn = 1; k = 0;
        push(0,    0, 0, 0, 12'h000, 1, 1, 0);
        push(1,    1, 0, 0, 12'h005, 1, 1, 1);
        push(656,  0, 0, 1, 12'h000, 1, 1, 0);
        push(657,  0, 0, 1, 12'h000, 0, 1, 0);
        push(752,  0, 0, 1, 12'h000, 0, 1, 0);
        push(753,  0, 0, 1, 12'h000, 1, 1, 0);
        push(1600, 0, 2, 0, 12'h000, 1, 1, 0);
        while (k < 1600) begin
            @(posedge clk);
            #1 k++;
        end
        @(negedge clk);
        #1;
        chk("row_max", k, row_max, 19);
        chk("sb_drained", k, sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
